// File: rtl/cpu_param.sv
// cpu_param: parametrised single-issue, non-pipelined core.
// RUN executes the instruction at PC; MEM holds a registered data access until BUSYWAIT drops.
module cpu_param #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    parameter int MEM_AW = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       INSTRUCTION,
    input  logic              INSTR_BUSYWAIT,
    output logic [31:0]       PC,
    output logic              READ,
    output logic              WRITE,
    output logic [MEM_AW-1:0] ADDRESS,
    output logic [DATA_W-1:0] WRITE_DATA,
    input  logic [DATA_W-1:0] READ_DATA,
    input  logic              BUSYWAIT
);
    localparam int REG_AW = $clog2(NREGS);

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_LWD   = 8'h08;
    localparam logic [7:0] OP_LWI   = 8'h09;
    localparam logic [7:0] OP_SWD   = 8'h0A;
    localparam logic [7:0] OP_SWI   = 8'h0B;
    localparam logic [7:0] OP_BNE   = 8'h0C;
    localparam logic [7:0] OP_SLL   = 8'h0D;
    localparam logic [7:0] OP_SRL   = 8'h0E;

    typedef enum logic {
        S_RUN,
        S_MEM
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] regs [NREGS];

    logic [7:0]        opcode;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic [DATA_W-1:0] rs1_val, rs2_val, imm_ext;
    logic [DATA_W-1:0] shl_res, shr_res, alu_res;
    logic [31:0]       shamt, pc_plus4, br_off, br_target, pc_next;
    logic              alu_we, is_mem, is_load, use_reg_addr;
    logic [MEM_AW-1:0] mem_addr;
    logic              reg_we;
    logic [DATA_W-1:0] reg_wd;
    logic              unused_bits;

    assign opcode  = INSTRUCTION[31:24];
    assign rd      = INSTRUCTION[16 +: REG_AW];
    assign rs1     = INSTRUCTION[8 +: REG_AW];
    assign rs2     = INSTRUCTION[0 +: REG_AW];
    assign rs1_val = regs[rs1];
    assign rs2_val = regs[rs2];
    assign imm_ext = DATA_W'($signed(INSTRUCTION[7:0]));

    assign unused_bits = ^INSTRUCTION;

    // Shift amounts of DATA_W or more flush the operand to zero.
    assign shamt   = {24'd0, INSTRUCTION[7:0]};
    assign shl_res = (shamt >= 32'(DATA_W)) ? '0 : rs1_val << shamt;
    assign shr_res = (shamt >= 32'(DATA_W)) ? '0 : rs1_val >> shamt;

    assign pc_plus4  = PC + 32'd4;
    assign br_off    = {{22{INSTRUCTION[23]}}, INSTRUCTION[23:16], 2'b00};
    assign br_target = pc_plus4 + br_off;

    always_comb begin
        alu_res      = '0;
        alu_we       = 1'b0;
        is_mem       = 1'b0;
        is_load      = 1'b0;
        use_reg_addr = 1'b0;
        pc_next      = pc_plus4;
        unique case (opcode)
            OP_LOADI: begin alu_res = imm_ext;           alu_we = 1'b1; end
            OP_MOV:   begin alu_res = rs2_val;           alu_we = 1'b1; end
            OP_ADD:   begin alu_res = rs1_val + rs2_val; alu_we = 1'b1; end
            OP_SUB:   begin alu_res = rs1_val + (~rs2_val + 1'b1); alu_we = 1'b1; end
            OP_AND:   begin alu_res = rs1_val & rs2_val; alu_we = 1'b1; end
            OP_OR:    begin alu_res = rs1_val | rs2_val; alu_we = 1'b1; end
            OP_SLL:   begin alu_res = shl_res;           alu_we = 1'b1; end
            OP_SRL:   begin alu_res = shr_res;           alu_we = 1'b1; end
            OP_J:     pc_next = br_target;
            OP_BEQ:   if (rs1_val == rs2_val) pc_next = br_target;
            OP_BNE:   if (rs1_val != rs2_val) pc_next = br_target;
            OP_LWD:   begin is_mem = 1'b1; is_load = 1'b1; use_reg_addr = 1'b1; end
            OP_LWI:   begin is_mem = 1'b1; is_load = 1'b1; end
            OP_SWD:   begin is_mem = 1'b1; use_reg_addr = 1'b1; end
            OP_SWI:   is_mem = 1'b1;
            default:  ;
        endcase
    end

    assign mem_addr = use_reg_addr ? MEM_AW'(rs2_val) : MEM_AW'(INSTRUCTION[7:0]);

    always_comb begin
        state_next = state;
        reg_we     = 1'b0;
        reg_wd     = alu_res;
        unique case (state)
            S_RUN: begin
                if (!INSTR_BUSYWAIT) begin
                    if (is_mem) state_next = S_MEM;
                    else        reg_we     = alu_we;
                end
            end
            S_MEM: begin
                // rd comes from the held instruction; READ marks a load in flight.
                if (!BUSYWAIT) begin
                    state_next = S_RUN;
                    reg_we     = READ;
                    reg_wd     = READ_DATA;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= S_RUN;
        else       state <= state_next;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            PC         <= '0;
            READ       <= 1'b0;
            WRITE      <= 1'b0;
            ADDRESS    <= '0;
            WRITE_DATA <= '0;
        end else if (state == S_RUN && !INSTR_BUSYWAIT) begin
            if (is_mem) begin
                READ       <= is_load;
                WRITE      <= !is_load;
                ADDRESS    <= mem_addr;
                WRITE_DATA <= rs1_val;
            end else begin
                PC <= pc_next;
            end
        end else if (state == S_MEM && !BUSYWAIT) begin
            READ  <= 1'b0;
            WRITE <= 1'b0;
            PC    <= pc_plus4;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[rd] <= reg_wd;
        end
    end

endmodule

// File: tb/tb_cpu_param.sv
// tb_cpu_param: random instruction stream checked against an ISA-level model,
// plus directed cases and a 16-bit/16-register instance.
module tb_cpu_param;
    localparam int DW = 8;
    localparam int NR = 8;
    localparam int AW = 8;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [31:0]   INSTRUCTION = 32'hFF00_0000;
    logic          INSTR_BUSYWAIT = 1'b0;
    logic [31:0]   PC;
    logic          READ, WRITE;
    logic [AW-1:0] ADDRESS;
    logic [DW-1:0] WRITE_DATA;
    logic [DW-1:0] READ_DATA = '0;
    logic          BUSYWAIT = 1'b0;

    logic          b_reset = 1'b1;
    logic [31:0]   b_ins = 32'hFF00_0000;
    logic          b_ibw = 1'b0;
    logic [31:0]   b_pc;
    logic          b_read, b_write;
    logic [7:0]    b_addr;
    logic [15:0]   b_wd;
    logic [15:0]   b_rdata = '0;
    logic          b_busy = 1'b0;

    always #5 CLK = ~CLK;

    cpu_param #(.DATA_W(DW), .NREGS(NR), .MEM_AW(AW)) dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION),
        .INSTR_BUSYWAIT(INSTR_BUSYWAIT), .PC(PC), .READ(READ), .WRITE(WRITE),
        .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA),
        .BUSYWAIT(BUSYWAIT)
    );

    cpu_param #(.DATA_W(16), .NREGS(16), .MEM_AW(8)) dut16 (
        .CLK(CLK), .RESET(b_reset), .INSTRUCTION(b_ins),
        .INSTR_BUSYWAIT(b_ibw), .PC(b_pc), .READ(b_read), .WRITE(b_write),
        .ADDRESS(b_addr), .WRITE_DATA(b_wd), .READ_DATA(b_rdata),
        .BUSYWAIT(b_busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0]   m_pc;
    logic [DW-1:0] m_r [NR];
    logic [DW-1:0] m_mem [256];
    logic [DW-1:0] last_wd;
    logic [AW-1:0] last_addr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] d,
                                       input logic [7:0] s1, input logic [7:0] s2);
        return {op, d, s1, s2};
    endfunction

    task automatic do_reset();
        RESET = 1'b1;
        INSTR_BUSYWAIT = 1'b0;
        BUSYWAIT = 1'b0;
        INSTRUCTION = 32'hFF00_0000;
        tick();
        RESET = 1'b0;
        m_pc = '0;
        foreach (m_r[i]) m_r[i] = '0;
        chk("rst_pc", 64'(PC), 64'd0);
        chk("rst_out", 64'({READ, WRITE, ADDRESS, WRITE_DATA}), 64'd0);
    endtask

    task automatic run_instr(input logic [31:0] ins, input int ibw, input int bw);
        logic [7:0]    op;
        int            rd, s1, s2, sh;
        logic [DW-1:0] a, b, imm, res;
        logic [AW-1:0] addr;
        logic [31:0]   pc0, tgt;
        bit            is_ld, is_st, we, take;
        op    = ins[31:24];
        rd    = int'(ins[23:16]) % NR;
        s1    = int'(ins[15:8]) % NR;
        s2    = int'(ins[7:0]) % NR;
        sh    = int'(ins[7:0]);
        a     = m_r[s1];
        b     = m_r[s2];
        imm   = DW'($signed(ins[7:0]));
        is_ld = (op == 8'h08) || (op == 8'h09);
        is_st = (op == 8'h0A) || (op == 8'h0B);
        addr  = (op == 8'h08 || op == 8'h0A) ? AW'(b) : AW'(ins[7:0]);
        pc0   = m_pc;
        INSTRUCTION = ins;
        INSTR_BUSYWAIT = 1'b1;
        repeat (ibw) begin
            tick();
            chk("ibw_pc", 64'(PC), 64'(pc0));
            chk("ibw_rw", 64'({READ, WRITE}), 64'd0);
        end
        INSTR_BUSYWAIT = 1'b0;
        BUSYWAIT = 1'($urandom_range(0, 1));
        tick();
        if (is_ld || is_st) begin
            chk("mem_req", 64'({READ, WRITE, ADDRESS}), 64'({is_ld, is_st, addr}));
            if (is_st) chk("mem_wd", 64'(WRITE_DATA), 64'(a));
            chk("mem_pc", 64'(PC), 64'(pc0));
            last_wd = WRITE_DATA;
            last_addr = ADDRESS;
            BUSYWAIT = 1'b1;
            repeat (bw) begin
                INSTR_BUSYWAIT = 1'($urandom_range(0, 1));
                READ_DATA = DW'($urandom);
                tick();
                chk("mem_hold", 64'({READ, WRITE, ADDRESS}), 64'({is_ld, is_st, addr}));
                if (is_st) chk("mem_hold_wd", 64'(WRITE_DATA), 64'(a));
                chk("mem_hold_pc", 64'(PC), 64'(pc0));
            end
            BUSYWAIT = 1'b0;
            READ_DATA = is_ld ? m_mem[addr] : DW'($urandom);
            tick();
            chk("mem_done", 64'({READ, WRITE, ADDRESS}), 64'({2'b00, addr}));
            if (is_ld) m_r[rd] = m_mem[addr];
            if (is_st) m_mem[addr] = a;
            m_pc = pc0 + 32'd4;
            INSTR_BUSYWAIT = 1'b0;
        end else begin
            we = 1'b1;
            res = '0;
            case (op)
                8'h00:   res = imm;
                8'h01:   res = b;
                8'h02:   res = a + b;
                8'h03:   res = a - b;
                8'h04:   res = a & b;
                8'h05:   res = a | b;
                8'h0D:   res = (sh >= DW) ? '0 : a << sh;
                8'h0E:   res = (sh >= DW) ? '0 : a >> sh;
                default: we = 1'b0;
            endcase
            if (we) m_r[rd] = res;
            tgt  = pc0 + 32'd4 + 32'(signed'(ins[23:16])) * 32'd4;
            take = (op == 8'h06) || (op == 8'h07 && a == b) || (op == 8'h0C && a != b);
            m_pc = take ? tgt : pc0 + 32'd4;
            chk("rw_idle", 64'({READ, WRITE}), 64'd0);
        end
        chk("pc", 64'(PC), 64'(m_pc));
    endtask

    task automatic peek(input logic [7:0] r);
        run_instr(mk(8'h0B, 8'h00, r, 8'hF0), 0, 0);
    endtask

    task automatic b_store(input string tag, input logic [15:0] exp);
        b_ins = mk(8'h0B, 8'h00, 8'h0F, 8'h00);
        tick();
        chk(tag, 64'({b_write, b_wd}), 64'({1'b1, exp}));
        tick();
    endtask

    logic [7:0] ops [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                             8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h3F};

    initial begin
        foreach (m_mem[i]) m_mem[i] = DW'($urandom);
        do_reset();

        run_instr(mk(8'h00, 8'h01, 8'h00, 8'h05), 0, 0);
        run_instr(mk(8'h00, 8'h02, 8'h00, 8'h03), 0, 0);
        run_instr(mk(8'h03, 8'h03, 8'h01, 8'h02), 0, 0);
        chk("pc_after3", 64'(PC), 64'd12);
        run_instr(mk(8'hFF, 8'h00, 8'h00, 8'h00), 0, 0);
        run_instr(mk(8'h07, 8'hFE, 8'h01, 8'h01), 0, 0);
        chk("beq_taken", 64'(PC), 64'd12);
        run_instr(mk(8'hFF, 8'h00, 8'h00, 8'h00), 0, 0);
        run_instr(mk(8'h0C, 8'hFE, 8'h01, 8'h01), 0, 0);
        chk("bne_nottaken", 64'(PC), 64'd20);
        peek(8'd3);
        chk("sub_r3", 64'(last_wd), 64'h02);
        run_instr(mk(8'h00, 8'h04, 8'h00, 8'hFF), 0, 0);
        run_instr(mk(8'h02, 8'h04, 8'h04, 8'h01), 0, 0);
        peek(8'd4);
        chk("add_wrap", 64'(last_wd), 64'h04);

        do_reset();
        run_instr(mk(8'h06, 8'h7F, 8'h00, 8'h00), 0, 0);
        chk("j_target", 64'(PC), 64'h200);

        do_reset();
        run_instr(mk(8'h00, 8'h01, 8'h00, 8'h05), 0, 0);
        run_instr(mk(8'h0B, 8'h00, 8'h01, 8'h10), 0, 3);
        chk("swi_addr", 64'(last_addr), 64'h10);
        chk("swi_data", 64'(last_wd), 64'h05);
        run_instr(mk(8'h00, 8'h02, 8'h00, 8'h03), 0, 0);
        m_mem[3] = 8'hA5;
        run_instr(mk(8'h08, 8'h05, 8'h00, 8'h02), 0, 1);
        chk("lwd_addr", 64'(last_addr), 64'h03);
        peek(8'd5);
        chk("lwd_r5", 64'(last_wd), 64'hA5);
        run_instr(mk(8'h02, 8'h01, 8'h01, 8'h01), 4, 0);
        peek(8'd1);
        chk("ibw_add_once", 64'(last_wd), 64'h0A);

        for (int n = 0; n < 400; n++) begin
            logic [7:0] op, s2;
            op = ops[$urandom_range(0, 15)];
            s2 = 8'($urandom);
            if (op == 8'h0D || op == 8'h0E) s2 = 8'($urandom_range(0, 9));
            run_instr(mk(op, 8'($urandom), 8'($urandom), s2),
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end

        INSTRUCTION = mk(8'h08, 8'h06, 8'h00, 8'h02);
        INSTR_BUSYWAIT = 1'b0;
        BUSYWAIT = 1'b1;
        tick();
        chk("rstmem_read", 64'(READ), 64'd1);
        tick();
        RESET = 1'b1;
        BUSYWAIT = 1'b0;
        READ_DATA = 8'h5A;
        tick();
        RESET = 1'b0;
        m_pc = '0;
        foreach (m_r[i]) m_r[i] = '0;
        chk("rstmem_rw", 64'({READ, WRITE}), 64'd0);
        chk("rstmem_pc", 64'(PC), 64'd0);
        peek(8'd6);
        chk("rstmem_r6", 64'(last_wd), 64'd0);

        b_reset = 1'b1;
        tick();
        b_reset = 1'b0;
        b_ins = mk(8'h00, 8'h0F, 8'h00, 8'h80);
        tick();
        b_store("w16_loadi", 16'hFF80);
        b_ins = mk(8'h0D, 8'h0F, 8'h0F, 8'h04);
        tick();
        b_store("w16_sll", 16'hF800);
        b_ins = mk(8'h0E, 8'h0F, 8'h0F, 8'h10);
        tick();
        b_store("w16_srl", 16'h0000);
        chk("w16_pc", 64'(b_pc), 64'd24);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
